// File: rtl/rom_upload.sv
// Serves HPS ioctl upload reads by fetching OS/BASIC/AMSDOS ROM bytes back out of
// SDRAM through the ce_ref-slotted port, using the same page/row/bank map as the loader.
module rom_upload #(
    parameter logic [7:0] INDEX    = 8'd0,
    parameter int         RD_SLOTS = 1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce_ref,
    input  logic        ioctl_upload,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    output logic        mem_rd,
    output logic [22:0] mem_a,
    output logic [1:0]  mem_bank,
    input  logic [7:0]  mem_dout,
    output logic        busy,
    output logic [7:0]  checksum
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SLOT = 2'd1;
    localparam logic [1:0] ST_READ = 2'd2;

    localparam logic [1:0] RD_LAST = 2'(RD_SLOTS - 1);

    logic [1:0]  state_q, state_d;
    logic        sel_q, sel_d;
    logic [1:0]  slot_cnt_q, slot_cnt_d;
    logic [7:0]  din_q, din_d;
    logic        wait_q, wait_d;
    logic        mem_rd_q, mem_rd_d;
    logic [22:0] mem_a_q, mem_a_d;
    logic [1:0]  bank_q, bank_d;
    logic        busy_q, busy_d;
    logic [7:0]  checksum_q, checksum_d;

    logic        sel;
    logic        in_map;
    logic [8:0]  map_row;
    logic [1:0]  map_bank;
    logic [10:0] page;

    assign sel  = ioctl_upload && (ioctl_index == INDEX);
    assign page = ioctl_addr[24:14];

    // Pages 3..5 mirror the row layout of pages 0..2 in bank 1; the low 14 bits never carry into the row.
    always_comb begin
        in_map   = 1'b1;
        map_row  = 9'h000;
        map_bank = (page >= 11'd3) ? 2'd1 : 2'd0;
        case (page)
            11'd0, 11'd3: map_row = 9'h000;
            11'd1, 11'd4: map_row = 9'h100;
            11'd2, 11'd5: map_row = 9'h107;
            default:      in_map  = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel;
        slot_cnt_d = slot_cnt_q;
        din_d      = din_q;
        wait_d     = wait_q;
        mem_rd_d   = mem_rd_q;
        mem_a_d    = mem_a_q;
        bank_d     = bank_q;
        checksum_d = checksum_q;

        if (sel && !sel_q) begin
            checksum_d = 8'h00;
        end

        case (state_q)
            ST_IDLE: begin
                if (ioctl_rd && sel) begin
                    if (in_map) begin
                        mem_a_d = {map_row, ioctl_addr[13:0]};
                        bank_d  = map_bank;
                        wait_d  = 1'b1;
                        state_d = ST_SLOT;
                    end else begin
                        din_d      = 8'hFF;
                        checksum_d = checksum_d ^ 8'hFF;
                    end
                end
            end
            ST_SLOT: begin
                if (!sel) begin
                    mem_rd_d = 1'b0;
                    wait_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else if (ce_ref) begin
                    mem_rd_d   = 1'b1;
                    slot_cnt_d = 2'd0;
                    state_d    = ST_READ;
                end
            end
            ST_READ: begin
                if (!sel) begin
                    mem_rd_d = 1'b0;
                    wait_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else if (ce_ref) begin
                    if (slot_cnt_q == RD_LAST) begin
                        din_d      = mem_dout;
                        checksum_d = checksum_d ^ mem_dout;
                        mem_rd_d   = 1'b0;
                        wait_d     = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        slot_cnt_d = slot_cnt_q + 2'd1;
                    end
                end
            end
            default: begin
                mem_rd_d = 1'b0;
                wait_d   = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= 1'b0;
            slot_cnt_q <= 2'd0;
            din_q      <= 8'hFF;
            wait_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_a_q    <= 23'd0;
            bank_q     <= 2'd0;
            busy_q     <= 1'b0;
            checksum_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            slot_cnt_q <= slot_cnt_d;
            din_q      <= din_d;
            wait_q     <= wait_d;
            mem_rd_q   <= mem_rd_d;
            mem_a_q    <= mem_a_d;
            bank_q     <= bank_d;
            busy_q     <= busy_d;
            checksum_q <= checksum_d;
        end
    end

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign mem_rd     = mem_rd_q;
    assign mem_a      = mem_a_q;
    assign mem_bank   = bank_q;
    assign busy       = busy_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_rom_upload.sv
// Directed bench for rom_upload: SDRAM byte model, free-running ce_ref every 16 clocks,
// expected read data queued on request and compared when ioctl_wait falls.
module tb_rom_upload;

    localparam int RD_SLOTS = 1;
    localparam int LAT_MIN  = 16 * RD_SLOTS + 1;
    localparam int LAT_MAX  = 16 * (RD_SLOTS + 1);

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ce_ref;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        mem_rd;
    logic [22:0] mem_a;
    logic [1:0]  mem_bank;
    logic [7:0]  mem_dout;
    logic        busy;
    logic [7:0]  checksum;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_csum;
    logic [7:0]  last_din;
    logic [3:0]  ce_cnt = 4'd0;

    rom_upload #(.INDEX(8'd0), .RD_SLOTS(RD_SLOTS)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ce_ref      (ce_ref),
        .ioctl_upload(ioctl_upload),
        .ioctl_index (ioctl_index),
        .ioctl_rd    (ioctl_rd),
        .ioctl_addr  (ioctl_addr),
        .ioctl_din   (ioctl_din),
        .ioctl_wait  (ioctl_wait),
        .mem_rd      (mem_rd),
        .mem_a       (mem_a),
        .mem_bank    (mem_bank),
        .mem_dout    (mem_dout),
        .busy        (busy),
        .checksum    (checksum)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] sdram_byte(input logic [1:0] b, input logic [22:0] a);
        case ({b, a})
            {2'd0, 23'h400123}: return 8'hA5;
            {2'd1, 23'h000000}: return 8'h3C;
            {2'd1, 23'h41FFFF}: return 8'hC3;
            {2'd0, 23'h000010}: return 8'h12;
            {2'd0, 23'h41C000}: return 8'h34;
            {2'd1, 23'h400000}: return 8'h56;
            default:            return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    assign mem_dout = mem_rd ? sdram_byte(mem_bank, mem_a) : 8'h00;

    initial begin
        ce_ref = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            ce_cnt = ce_cnt + 4'd1;
            ce_ref = (ce_cnt == 4'd0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    // Watch n cycles and report whether ioctl_wait or mem_rd was ever seen high.
    task automatic watch(input int n, output bit saw);
        saw = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
            if (ioctl_wait !== 1'b0 || mem_rd !== 1'b0) saw = 1'b1;
        end
    endtask

    task automatic do_read(input string tag, input logic [24:0] addr, input logic [22:0] exp_a,
                           input logic [1:0] exp_bank, input logic [7:0] exp_byte, input bit poke_busy);
        int   lat;
        bit   saw_rd;
        logic [7:0] expd;
        exp_q.push_back(exp_byte);
        ioctl_addr = addr;
        ioctl_rd   = 1'b1;
        @(posedge clk_sys);
        #1;
        ioctl_rd = 1'b0;
        check({tag, ".wait_rise"}, ioctl_wait, 1);
        check({tag, ".mem_a"}, mem_a, exp_a);
        check({tag, ".bank"}, mem_bank, exp_bank);
        lat    = 1;
        saw_rd = 1'b0;
        if (poke_busy) begin
            ioctl_addr = addr ^ 25'h08000;
            ioctl_rd   = 1'b1;
            @(posedge clk_sys);
            #1;
            ioctl_rd = 1'b0;
            lat++;
            if (mem_rd === 1'b1) saw_rd = 1'b1;
            check({tag, ".busy_ignore_a"}, mem_a, exp_a);
        end
        while (ioctl_wait === 1'b1 && lat < 400) begin
            @(posedge clk_sys);
            #1;
            lat++;
            if (mem_rd === 1'b1) saw_rd = 1'b1;
        end
        check({tag, ".wait_fall"}, ioctl_wait, 0);
        check({tag, ".latency_ok"}, (lat >= LAT_MIN && lat <= LAT_MAX), 1);
        check({tag, ".saw_mem_rd"}, saw_rd, 1);
        check({tag, ".mem_rd_off"}, mem_rd, 0);
        check({tag, ".busy_off"}, busy, 0);
        expd = exp_q.pop_front();
        check({tag, ".din"}, ioctl_din, expd);
        exp_csum = exp_csum ^ expd;
        last_din = expd;
        check({tag, ".checksum"}, checksum, exp_csum);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".din"}, ioctl_din, 8'hFF);
        check({tag, ".wait"}, ioctl_wait, 0);
        check({tag, ".mem_rd"}, mem_rd, 0);
        check({tag, ".mem_a"}, mem_a, 0);
        check({tag, ".bank"}, mem_bank, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".checksum"}, checksum, 0);
    endtask

    initial begin
        bit   saw;
        int   guard;

        reset_n      = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_index  = 8'd0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = 25'd0;
        exp_csum     = 8'h00;
        last_din     = 8'hFF;
        tick(3);
        check_reset_values("reset");
        reset_n = 1'b1;
        tick(2);

        ioctl_upload = 1'b1;
        tick(2);
        do_read("page_map", 25'h04123, 23'h400123, 2'd0, 8'hA5, 1'b0);
        do_read("bank_p3",  25'h0C000, 23'h000000, 2'd1, 8'h3C, 1'b0);
        do_read("bank_p5",  25'h17FFF, 23'h41FFFF, 2'd1, 8'hC3, 1'b0);

        // Out-of-map page answers FF immediately without touching SDRAM.
        ioctl_addr = 25'h18000;
        ioctl_rd   = 1'b1;
        tick(1);
        ioctl_rd = 1'b0;
        check("oom.din", ioctl_din, 8'hFF);
        check("oom.wait", ioctl_wait, 0);
        check("oom.busy", busy, 0);
        exp_csum = exp_csum ^ 8'hFF;
        check("oom.checksum", checksum, exp_csum);
        watch(20, saw);
        check("oom.no_access", saw, 0);

        ioctl_upload = 1'b0;
        tick(2);
        ioctl_upload = 1'b1;
        tick(1);
        exp_csum = 8'h00;
        check("session.clear", checksum, 8'h00);
        do_read("sess_b0", 25'h00010, 23'h000010, 2'd0, 8'h12, 1'b0);
        do_read("sess_b1", 25'h08000, 23'h41C000, 2'd0, 8'h34, 1'b0);
        do_read("sess_b2", 25'h10000, 23'h400000, 2'd1, 8'h56, 1'b0);
        check("session.sum70", checksum, 8'h70);

        ioctl_index = 8'd3;
        tick(1);
        ioctl_addr = 25'h04123;
        ioctl_rd   = 1'b1;
        tick(1);
        ioctl_rd = 1'b0;
        watch(20, saw);
        check("wrong_index.no_access", saw, 0);
        check("wrong_index.busy", busy, 0);
        check("wrong_index.din", ioctl_din, 8'h56);
        check("wrong_index.checksum", checksum, 8'h70);

        ioctl_index = 8'd0;
        tick(1);
        exp_csum = 8'h00;
        check("reselect.clear", checksum, 8'h00);
        do_read("busy_ignore", 25'h04123, 23'h400123, 2'd0, 8'hA5, 1'b1);

        // Drop the session while the SDRAM read is in flight.
        ioctl_addr = 25'h00010;
        ioctl_rd   = 1'b1;
        tick(1);
        ioctl_rd = 1'b0;
        guard    = 0;
        while (mem_rd !== 1'b1 && guard < 40) begin
            tick(1);
            guard++;
        end
        check("abort.in_read", mem_rd, 1);
        ioctl_upload = 1'b0;
        tick(1);
        check("abort.wait", ioctl_wait, 0);
        check("abort.mem_rd", mem_rd, 0);
        check("abort.busy", busy, 0);
        check("abort.din", ioctl_din, last_din);
        check("abort.checksum", checksum, exp_csum);

        ioctl_upload = 1'b1;
        tick(2);
        ioctl_addr = 25'h04123;
        ioctl_rd   = 1'b1;
        tick(1);
        ioctl_rd = 1'b0;
        check("slot.wait", ioctl_wait, 1);
        check("slot.busy", busy, 1);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        tick(2);
        reset_n = 1'b1;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
